// File: rtl/afc_bsearch_gen.sv
// ---------------------------------------------------------------------------
// afc_bsearch_gen
// VCO automatic frequency calibration engine. It runs a binary search over
// the capacitor band. For each code it settles the VCO, gates the analog
// frequency counter for a programmable window, and compares the count against
// the divider target. It keeps the code with the smallest |count - target|.
// An optional +/-1 pass then re-evaluates the neighbours of that best code.
//
// Ports
//   i_clk, i_rstn               clock, asynchronous active-low reset
//   i_afc_en                    rising edge launches a calibration
//   i_divr                      target count
//   i_rg_forceband_en           skip the search and use i_rg_vco_capband
//   i_rg_vco_capband            forced band
//   i_rg_afc_vcostable_time     settle time = (value+1)*STB_UNIT cycles
//   i_rg_afc_cnt_time           count window in cycles, 0 selects 2^TCNT_W
//   i_rg_refine_en              enable the +/-1 refinement pass
//   i_a2d_afc_ncntr             analog counter result
//   o_afc_openloop_en, o_afc_busy   high while a calibration runs
//   o_afc_vco_capband           band driven to the VCO
//   o_afc_cntr_rstn/_en/_datasyn    analog counter reset, gate, result sync
//   o_afc_minerr                best error, saturated to CNT_W bits
//   o_afc_step_cnt              number of codes evaluated
//   o_afc_finish                level, high from completion until next start
// All outputs are registered from the current FSM state, so they trail the
// state by one cycle.
// ---------------------------------------------------------------------------
module afc_bsearch_gen #(
  parameter int CAP_W    = 7,
  parameter int CNT_W    = 15,
  parameter int DIVR_W   = 16,
  parameter int TCNT_W   = 7,
  parameter int STB_UNIT = 16
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_afc_en,
  input  logic [DIVR_W-1:0] i_divr,
  input  logic              i_rg_forceband_en,
  input  logic [CAP_W-1:0]  i_rg_vco_capband,
  input  logic [1:0]        i_rg_afc_vcostable_time,
  input  logic [TCNT_W-1:0] i_rg_afc_cnt_time,
  input  logic              i_rg_refine_en,
  input  logic [CNT_W-1:0]  i_a2d_afc_ncntr,
  output logic              o_afc_openloop_en,
  output logic [CAP_W-1:0]  o_afc_vco_capband,
  output logic              o_afc_cntr_rstn,
  output logic              o_afc_cntr_en,
  output logic              o_afc_cntr_datasyn,
  output logic [CNT_W-1:0]  o_afc_minerr,
  output logic              o_afc_busy,
  output logic [3:0]        o_afc_step_cnt,
  output logic              o_afc_finish
);

  localparam int K_W   = (CAP_W > 1) ? $clog2(CAP_W) : 1;
  localparam int ERR_W = DIVR_W + 1;
  localparam int STL_W = $clog2(4 * STB_UNIT) + 1;
  localparam int TMR_W = (STL_W > TCNT_W + 1) ? STL_W : TCNT_W + 1;
  localparam logic [CAP_W-1:0] CODE_MID = CAP_W'(1) << (CAP_W - 1);
  localparam logic [CAP_W-1:0] CODE_MAX = {CAP_W{1'b1}};
  localparam logic [K_W-1:0]   K_TOP    = K_W'(CAP_W - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_SETTLE = 3'd2,
    S_COUNT  = 3'd3,
    S_SYNC   = 3'd4,
    S_EVAL   = 3'd5,
    S_REFINE = 3'd6,
    S_DONE   = 3'd7
  } state_e;

  // Saturate an error magnitude into the CNT_W-bit status field.
  function automatic logic [CNT_W-1:0] sat_cnt(input logic [ERR_W-1:0] val);
    logic [ERR_W-1:0] lim;
    lim = ERR_W'({CNT_W{1'b1}});
    if (val > lim) begin
      sat_cnt = {CNT_W{1'b1}};
    end else begin
      sat_cnt = val[CNT_W-1:0];
    end
  endfunction

  state_e              r_state;
  state_e              w_state_nxt;
  logic                r_afc_en_d;
  logic                w_start;
  logic [CAP_W-1:0]    r_code;
  logic [K_W-1:0]      r_k;
  logic [CAP_W-1:0]    r_best_code;
  logic [ERR_W-1:0]    r_best_err;
  logic [TMR_W-1:0]    r_timer;
  logic [CNT_W-1:0]    r_ncntr;
  logic [1:0]          r_pend;      // [0] minus neighbour pending, [1] plus
  logic [CAP_W-1:0]    r_ref_base;
  logic                r_refining;
  logic                r_forced;

  logic [TMR_W-1:0]    w_settle_ld;
  logic [TCNT_W-1:0]   w_win_m1;
  logic [TMR_W-1:0]    w_win_ld;
  logic [DIVR_W-1:0]   w_ncntr_ext;
  logic [ERR_W-1:0]    w_err;
  logic [ERR_W-1:0]    w_abs;
  logic                w_better;
  logic                w_keep;
  logic [CAP_W-1:0]    w_bit_k;
  logic [CAP_W-1:0]    w_bit_km1;
  logic [CAP_W-1:0]    w_code_kept;
  logic [CAP_W-1:0]    w_ref_base;
  logic                w_ref_minus_ok;
  logic                w_ref_plus_ok;

  logic                r_openloop, w_openloop;
  logic [CAP_W-1:0]    r_capband, w_capband;
  logic                r_cntr_rstn, w_cntr_rstn;
  logic                r_cntr_en, w_cntr_en;
  logic                r_datasyn, w_datasyn;
  logic [CNT_W-1:0]    r_minerr, w_minerr;
  logic [3:0]          r_step_cnt, w_step_cnt;
  logic                r_finish, w_finish;

  // afc_en edge detector; a held-high enable does not retrigger.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_afc_en_d <= 1'b0;
    end else begin
      r_afc_en_d <= i_afc_en;
    end
  end

  // Timer loads, error arithmetic and search/refine decisions.
  always_comb begin
    w_start     = i_afc_en & ~r_afc_en_d;
    w_settle_ld = TMR_W'((int'(i_rg_afc_vcostable_time) + 1) * STB_UNIT - 1);
    // A zero window wraps to all ones, which gives the 2^TCNT_W window.
    w_win_m1    = i_rg_afc_cnt_time - TCNT_W'(1);
    w_win_ld    = TMR_W'(w_win_m1);
    w_ncntr_ext = DIVR_W'(r_ncntr);
    w_err       = {1'b0, w_ncntr_ext} - {1'b0, i_divr};
    if (w_err[ERR_W-1]) begin
      w_abs = ERR_W'(0) - w_err;
    end else begin
      w_abs = w_err;
    end
    w_better = (w_abs < r_best_err);
    w_keep   = ~w_err[ERR_W-1];
    w_bit_k  = CAP_W'(1) << r_k;
    if (r_k != K_W'(0)) begin
      w_bit_km1 = CAP_W'(1) << (r_k - K_W'(1));
    end else begin
      w_bit_km1 = '0;
    end
    if (w_keep) begin
      w_code_kept = r_code;
    end else begin
      w_code_kept = r_code & ~w_bit_k;
    end
    // The base is latched on the first REFINE visit, so a better minus
    // neighbour does not move the plus neighbour.
    if (r_pend == 2'b11) begin
      w_ref_base = r_best_code;
    end else begin
      w_ref_base = r_ref_base;
    end
    w_ref_minus_ok = r_pend[0] && (w_ref_base != '0);
    w_ref_plus_ok  = r_pend[1] && (w_ref_base != CODE_MAX);
  end

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start) w_state_nxt = S_START;
        else         w_state_nxt = S_IDLE;
      end
      S_START: begin
        if (i_rg_forceband_en) w_state_nxt = S_DONE;
        else                   w_state_nxt = S_SETTLE;
      end
      S_SETTLE: begin
        if (r_timer == '0) w_state_nxt = S_COUNT;
        else               w_state_nxt = S_SETTLE;
      end
      S_COUNT: begin
        if (r_timer == '0) w_state_nxt = S_SYNC;
        else               w_state_nxt = S_COUNT;
      end
      S_SYNC: begin
        if (r_timer == '0) w_state_nxt = S_EVAL;
        else               w_state_nxt = S_SYNC;
      end
      S_EVAL: begin
        if (r_refining)               w_state_nxt = S_REFINE;
        else if (r_k != K_W'(0))      w_state_nxt = S_SETTLE;
        else if (i_rg_refine_en)      w_state_nxt = S_REFINE;
        else                          w_state_nxt = S_DONE;
      end
      S_REFINE: begin
        if (w_ref_minus_ok || w_ref_plus_ok) w_state_nxt = S_SETTLE;
        else                                 w_state_nxt = S_DONE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Search datapath: code/bit pointer, timers, sampled count, best tracking.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_code      <= CODE_MID;
      r_k         <= K_TOP;
      r_best_code <= CODE_MID;
      r_best_err  <= '1;
      r_timer     <= '0;
      r_ncntr     <= '0;
      r_pend      <= 2'b00;
      r_ref_base  <= '0;
      r_refining  <= 1'b0;
      r_forced    <= 1'b0;
    end else begin
      case (r_state)
        S_START: begin
          r_code      <= CODE_MID;
          r_k         <= K_TOP;
          r_best_code <= CODE_MID;
          r_best_err  <= '1;
          r_pend      <= 2'b00;
          r_refining  <= 1'b0;
          r_forced    <= i_rg_forceband_en;
          r_timer     <= w_settle_ld;
        end
        S_SETTLE: begin
          if (r_timer == '0) r_timer <= w_win_ld;
          else               r_timer <= r_timer - TMR_W'(1);
        end
        S_COUNT: begin
          if (r_timer == '0) r_timer <= TMR_W'(1);
          else               r_timer <= r_timer - TMR_W'(1);
        end
        S_SYNC: begin
          if (r_timer == '0) r_ncntr <= i_a2d_afc_ncntr;
          else               r_timer <= r_timer - TMR_W'(1);
        end
        S_EVAL: begin
          r_timer <= w_settle_ld;
          if (w_better) begin
            r_best_err  <= w_abs;
            r_best_code <= r_code;
          end
          if (!r_refining) begin
            if (r_k != K_W'(0)) begin
              r_code <= w_code_kept | w_bit_km1;
              r_k    <= r_k - K_W'(1);
            end else begin
              r_code     <= w_code_kept;
              r_pend     <= 2'b11;
              r_refining <= 1'b1;
            end
          end
        end
        S_REFINE: begin
          r_timer <= w_settle_ld;
          if (r_pend == 2'b11) r_ref_base <= r_best_code;
          if (w_ref_minus_ok) begin
            r_code <= w_ref_base - CAP_W'(1);
            r_pend <= 2'b10;
          end else if (w_ref_plus_ok) begin
            r_code <= w_ref_base + CAP_W'(1);
            r_pend <= 2'b00;
          end else begin
            r_pend <= 2'b00;
          end
        end
        default: r_timer <= r_timer;
      endcase
    end
  end

  // FSM output logic (next values of the registered outputs).
  always_comb begin
    w_openloop  = 1'b0;
    w_capband   = r_capband;
    w_cntr_rstn = 1'b0;
    w_cntr_en   = 1'b0;
    w_datasyn   = 1'b0;
    w_minerr    = r_minerr;
    w_step_cnt  = r_step_cnt;
    w_finish    = r_finish;
    case (r_state)
      S_IDLE: begin
        w_openloop = 1'b0;
      end
      S_START: begin
        w_openloop = 1'b1;
        w_finish   = 1'b0;
        w_step_cnt = 4'd0;
      end
      S_SETTLE: begin
        w_openloop = 1'b1;
        w_capband  = r_code;
      end
      S_COUNT: begin
        w_openloop  = 1'b1;
        w_cntr_rstn = 1'b1;
        w_cntr_en   = 1'b1;
      end
      S_SYNC: begin
        w_openloop  = 1'b1;
        w_cntr_rstn = 1'b1;
        w_datasyn   = 1'b1;
      end
      S_EVAL: begin
        w_openloop  = 1'b1;
        w_cntr_rstn = 1'b1;
        w_step_cnt  = r_step_cnt + 4'd1;
      end
      S_REFINE: begin
        w_openloop = 1'b1;
      end
      S_DONE: begin
        w_finish = 1'b1;
        if (r_forced) begin
          w_capband = i_rg_vco_capband;
          w_minerr  = {CNT_W{1'b1}};
        end else begin
          w_capband = r_best_code;
          w_minerr  = sat_cnt(r_best_err);
        end
      end
      default: w_openloop = 1'b0;
    endcase
  end

  // Output registers.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_openloop  <= 1'b0;
      r_capband   <= CODE_MID;
      r_cntr_rstn <= 1'b0;
      r_cntr_en   <= 1'b0;
      r_datasyn   <= 1'b0;
      r_minerr    <= {CNT_W{1'b1}};
      r_step_cnt  <= 4'd0;
      r_finish    <= 1'b0;
    end else begin
      r_openloop  <= w_openloop;
      r_capband   <= w_capband;
      r_cntr_rstn <= w_cntr_rstn;
      r_cntr_en   <= w_cntr_en;
      r_datasyn   <= w_datasyn;
      r_minerr    <= w_minerr;
      r_step_cnt  <= w_step_cnt;
      r_finish    <= w_finish;
    end
  end

  assign o_afc_openloop_en  = r_openloop;
  assign o_afc_busy         = r_openloop;
  assign o_afc_vco_capband  = r_capband;
  assign o_afc_cntr_rstn    = r_cntr_rstn;
  assign o_afc_cntr_en      = r_cntr_en;
  assign o_afc_cntr_datasyn = r_datasyn;
  assign o_afc_minerr       = r_minerr;
  assign o_afc_step_cnt     = r_step_cnt;
  assign o_afc_finish       = r_finish;

endmodule

// File: tb/tb_afc_bsearch_gen.sv
// ---------------------------------------------------------------------------
// Bench for afc_bsearch_gen (default parameters). The analog counter is a
// function of the driven capband. A reference model of the search pushes the
// expected evaluated codes and final status to queues. A monitor pops one
// code per counter gate and checks the gate width. The run task pops the
// final status when finish rises.
// ---------------------------------------------------------------------------
module tb_afc_bsearch_gen;

  logic        clk = 1'b0;
  logic        rstn;
  logic        afc_en;
  logic [15:0] divr;
  logic        forceband;
  logic [6:0]  fcap;
  logic [1:0]  vst;
  logic [6:0]  cnt_time;
  logic        refine_en;
  logic [14:0] a2d;
  logic        o_openloop, o_cntr_rstn, o_cntr_en, o_datasyn, o_busy, o_finish;
  logic [6:0]  o_cap;
  logic [14:0] o_minerr;
  logic [3:0]  o_step;

  typedef struct {
    int cap;
    int minerr;
    int step;
    int lat;
  } exp_t;

  exp_t q_fin[$];
  int   q_code[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   exp_win = 8;
  int   n_en_rise = 0;
  int   cur_mode = 0;

  always #5 clk = ~clk;

  afc_bsearch_gen dut (
    .i_clk                   (clk),
    .i_rstn                  (rstn),
    .i_afc_en                (afc_en),
    .i_divr                  (divr),
    .i_rg_forceband_en       (forceband),
    .i_rg_vco_capband        (fcap),
    .i_rg_afc_vcostable_time (vst),
    .i_rg_afc_cnt_time       (cnt_time),
    .i_rg_refine_en          (refine_en),
    .i_a2d_afc_ncntr         (a2d),
    .o_afc_openloop_en       (o_openloop),
    .o_afc_vco_capband       (o_cap),
    .o_afc_cntr_rstn         (o_cntr_rstn),
    .o_afc_cntr_en           (o_cntr_en),
    .o_afc_cntr_datasyn      (o_datasyn),
    .o_afc_minerr            (o_minerr),
    .o_afc_busy              (o_busy),
    .o_afc_step_cnt          (o_step),
    .o_afc_finish            (o_finish)
  );

  // Analog counter model: 0 -> 300-2*cap, 1 -> constant 10, 2 -> 300-cap.
  function automatic logic [14:0] ncntr_model(input int mode, input logic [6:0] cap);
    int v;
    case (mode)
      0:       v = 300 - 2 * int'(cap);
      1:       v = 10;
      default: v = 300 - int'(cap);
    endcase
    return 15'(v);
  endfunction

  assign a2d = ncntr_model(cur_mode, o_cap);

  task automatic check_eq(input string tag, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference search: pushes evaluated codes, returns the final status.
  task automatic model_search(input int mode, input int dv, input bit refine, output exp_t e);
    int code, best, best_err, err, nc, n, base, cand;
    code = 64; best = 64; best_err = 1 << 30; n = 0;
    for (int k = 6; k >= 0; k--) begin
      q_code.push_back(code);
      n++;
      nc  = int'(ncntr_model(mode, 7'(code)));
      err = (nc > dv) ? nc - dv : dv - nc;
      if (err < best_err) begin best_err = err; best = code; end
      if (nc < dv) code = code & ~(1 << k);
      if (k > 0) code = code | (1 << (k - 1));
    end
    if (refine) begin
      base = best;
      for (int d = -1; d <= 1; d += 2) begin
        cand = base + d;
        if (cand >= 0 && cand <= 127) begin
          q_code.push_back(cand);
          n++;
          nc  = int'(ncntr_model(mode, 7'(cand)));
          err = (nc > dv) ? nc - dv : dv - nc;
          if (err < best_err) begin best_err = err; best = cand; end
        end
      end
    end
    e.cap    = best;
    e.minerr = (best_err > 32767) ? 32767 : best_err;
    e.step   = n;
    e.lat    = -1;
  endtask

  // Counter gate monitor: expected code per gate and gate width.
  int   en_len = 0;
  logic prev_en = 1'b0;
  always @(posedge clk) begin
    #1;
    if (!rstn) begin
      en_len  = 0;
      prev_en = 1'b0;
    end else begin
      if (o_cntr_en && !prev_en) begin
        n_en_rise++;
        check_eq("code_expected", q_code.size() > 0, 1);
        if (q_code.size() > 0) check_eq("eval_code", o_cap, q_code.pop_front());
        en_len = 1;
      end else if (o_cntr_en) begin
        en_len++;
      end else if (prev_en) begin
        check_eq("window_len", en_len, exp_win);
      end
      prev_en = o_cntr_en;
    end
  end

  task automatic check_reset_vals();
    check_eq("rst_capband", o_cap, 64);
    check_eq("rst_openloop", o_openloop, 0);
    check_eq("rst_cntr_rstn", o_cntr_rstn, 0);
    check_eq("rst_cntr_en", o_cntr_en, 0);
    check_eq("rst_datasyn", o_datasyn, 0);
    check_eq("rst_minerr", o_minerr, 32767);
    check_eq("rst_busy", o_busy, 0);
    check_eq("rst_step", o_step, 0);
    check_eq("rst_finish", o_finish, 0);
  endtask

  task automatic run_cal(input int mode, input int dv, input int vs, input int win,
                         input bit refine, input bit force_en, input int fcode,
                         input bit glitch);
    exp_t e;
    int   cyc;
    @(negedge clk);
    cur_mode = mode; divr = 16'(dv); vst = 2'(vs); cnt_time = 7'(win);
    refine_en = refine; forceband = force_en; fcap = 7'(fcode);
    exp_win = (win == 0) ? 128 : win;
    if (force_en) begin
      e.cap = fcode; e.minerr = 32767; e.step = 0; e.lat = 2;
    end else begin
      model_search(mode, dv, refine, e);
      if (!refine) e.lat = e.step * ((vs + 1) * 16 + exp_win + 3) + 2;
    end
    q_fin.push_back(e);
    afc_en = 1'b1;
    @(posedge clk); #1;
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1) check_eq("busy_on", o_busy, 1);
      if (glitch && cyc == 30) afc_en = 1'b0;
      if (glitch && cyc == 32) afc_en = 1'b1;
    end while (!o_finish && cyc < 5000);
    check_eq("finish_seen", o_finish, 1);
    e = q_fin.pop_front();
    check_eq("final_capband", o_cap, e.cap);
    check_eq("final_minerr", o_minerr, e.minerr);
    check_eq("final_step_cnt", o_step, e.step);
    if (e.lat >= 0) check_eq("finish_latency", cyc, e.lat);
    check_eq("done_busy", o_busy, 0);
    check_eq("done_openloop", o_openloop, 0);
    check_eq("done_cntr_rstn", o_cntr_rstn, 0);
    check_eq("codes_left", q_code.size(), 0);
    repeat (20) @(posedge clk);
    #1;
    check_eq("held_finish", o_finish, 1);
    check_eq("held_busy", o_busy, 0);
    @(negedge clk);
    afc_en = 1'b0;
    q_code.delete();
  endtask

  initial begin
    exp_t dummy;
    int   base;
    int   w;
    rstn = 1'b0; afc_en = 1'b0; divr = 16'd101; forceband = 1'b0; fcap = 7'd0;
    vst = 2'd0; cnt_time = 7'd8; refine_en = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (1000) @(posedge clk);
    #1;
    check_reset_vals();

    run_cal(0, 101, 0, 8, 1'b0, 1'b0, 0, 1'b0);
    run_cal(0, 101, 0, 8, 1'b1, 1'b0, 0, 1'b0);
    run_cal(1, 100, 0, 8, 1'b1, 1'b0, 0, 1'b0);
    run_cal(2, 100, 0, 8, 1'b1, 1'b0, 0, 1'b0);
    run_cal(0, 101, 1, 0, 1'b0, 1'b0, 0, 1'b0);
    run_cal(0, 101, 0, 8, 1'b0, 1'b1, 37, 1'b0);

    // Reset during the third counting window.
    @(negedge clk);
    cur_mode = 0; divr = 16'd101; vst = 2'd0; cnt_time = 7'd8;
    refine_en = 1'b0; forceband = 1'b0; exp_win = 8;
    model_search(0, 101, 1'b0, dummy);
    base = n_en_rise;
    afc_en = 1'b1;
    w = 0;
    while (n_en_rise < base + 3 && w < 3000) begin
      @(posedge clk); #1;
      w++;
    end
    check_eq("reached_3rd_count", n_en_rise - base, 3);
    check_eq("in_count", o_cntr_en, 1);
    @(negedge clk);
    rstn = 1'b0;
    afc_en = 1'b0;
    #1;
    check_reset_vals();
    @(posedge clk); #1;
    check_reset_vals();
    q_code.delete();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    run_cal(0, 101, 0, 8, 1'b0, 1'b0, 0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
